// File: rtl/atm_mem_pkg.sv
// atm_mem_pkg: shared types and constants for the ATM memory subsystem DOS sequencer.
package atm_mem_pkg;
  typedef enum logic [1:0] {IDLE, STALL, WAITM1} dos_st_t;
  localparam logic [7:0] DOS_ENTRY_PAGE = 8'h3D;
  localparam int DOS_CNT_W = 3;
endpackage

// File: rtl/atm_m1_detect.sv
// atm_m1_detect: one-shot opcode-fetch strobe, re-armed once M1 release is seen on zneg.
module atm_m1_detect (
  input  logic fclk,
  input  logic arst_n,
  input  logic zpos,
  input  logic zneg,
  input  logic m1_n,
  input  logic mreq_n,
  input  logic rfsh_n,
  output logic fetch
);
  logic armed_q, armed_d;
  assign fetch = armed_q & zpos & ~m1_n & ~mreq_n & rfsh_n;
  always_comb armed_d = fetch ? 1'b0 : (zneg & m1_n) ? 1'b1 : armed_q;
  always_ff @(posedge fclk or negedge arst_n)
    if (!arst_n) armed_q <= 1'b1;
    else armed_q <= armed_d;
endmodule

// File: rtl/atm_dos_ctrl.sv
// atm_dos_ctrl: TR-DOS page-in/page-out sequencer with Z80 clock stall.
// ATM_DOS_AUTOEXIT_EN enables automatic DOS exit on a fetch from a RAM window.
module atm_dos_ctrl
  import atm_mem_pkg::*;
#(
  parameter int STALL_CYC = 4
) (
  input  logic       fclk,
  input  logic       arst_n,
  input  logic       zpos,
  input  logic       zneg,
  input  logic [15:0] za,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic       rfsh_n,
  input  logic       pager_off,
  input  logic       dos,
  input  logic [3:0] win_romnram,
  input  logic [3:0] win_dos_7ffd,
  input  logic       pent1m_ROM,
  output logic       dos_turn_on,
  output logic       dos_turn_off,
  output logic       zclk_stall,
  output logic       busy
);
  dos_st_t state_q, state_d;
  logic [DOS_CNT_W-1:0] cnt_q, cnt_d;
  logic on_q, on_d, off_q, off_d;
  logic fetch, entry_c, exit_c;
  logic unused_bits;
  atm_m1_detect u_m1 (
    .fclk(fclk), .arst_n(arst_n), .zpos(zpos), .zneg(zneg),
    .m1_n(m1_n), .mreq_n(mreq_n), .rfsh_n(rfsh_n), .fetch(fetch)
  );
  assign entry_c = !pager_off && !dos && za[15:8] == DOS_ENTRY_PAGE &&
                   win_romnram[0] && win_dos_7ffd[0] && pent1m_ROM;
`ifdef ATM_DOS_AUTOEXIT_EN
  assign exit_c = !pager_off && dos && !win_romnram[za[15:14]];
  assign unused_bits = ^{za[7:0], win_dos_7ffd[3:1]};
`else
  assign exit_c = 1'b0;
  assign unused_bits = ^{za[7:0], win_dos_7ffd[3:1], win_romnram[3:1]};
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    on_d = 1'b0;
    off_d = 1'b0;
    case (state_q)
      IDLE:
        if (fetch && entry_c) begin
          state_d = STALL;
          on_d = 1'b1;
          cnt_d = DOS_CNT_W'(STALL_CYC - 1);
        end else off_d = fetch && exit_c;
      STALL:
        if (cnt_q == '0) state_d = WAITM1;
        else cnt_d = cnt_q - 1'b1;
      WAITM1: state_d = (zneg && m1_n) ? IDLE : WAITM1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge fclk or negedge arst_n)
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      on_q <= 1'b0;
      off_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      on_q <= on_d;
      off_q <= off_d;
    end
  assign dos_turn_on = on_q;
  assign dos_turn_off = off_q;
  assign zclk_stall = state_q == STALL;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_atm_dos_ctrl.sv
// tb_atm_dos_ctrl: scoreboard bench for the DOS sequencer (entry, exit, one-shot, inhibit, reset).
module tb_atm_dos_ctrl;
  logic fclk = 0, arst_n = 0, zpos = 0, zneg = 0;
  logic [15:0] za = 16'h0000;
  logic m1_n = 1, mreq_n = 1, rfsh_n = 1;
  logic pager_off = 0, dos = 0, pent1m_ROM = 1;
  logic [3:0] win_romnram = 4'b0001, win_dos_7ffd = 4'b0001;
  logic dos_turn_on, dos_turn_off, zclk_stall, busy;
  int n_tests = 0, n_fail = 0;
  int on_tot = 0, off_tot = 0, st_tot = 0, on_wo_st = 0;
  typedef struct {int on; int off; int st; logic bw;} exp_t;
  exp_t exp_q[$];
`ifdef ATM_DOS_AUTOEXIT_EN
  localparam int EXP_OFF = 1;
`else
  localparam int EXP_OFF = 0;
`endif
  atm_dos_ctrl #(.STALL_CYC(4)) dut (
    .fclk(fclk), .arst_n(arst_n), .zpos(zpos), .zneg(zneg), .za(za),
    .m1_n(m1_n), .mreq_n(mreq_n), .rfsh_n(rfsh_n), .pager_off(pager_off),
    .dos(dos), .win_romnram(win_romnram), .win_dos_7ffd(win_dos_7ffd),
    .pent1m_ROM(pent1m_ROM), .dos_turn_on(dos_turn_on),
    .dos_turn_off(dos_turn_off), .zclk_stall(zclk_stall), .busy(busy)
  );
  always #5 fclk = ~fclk;
  always @(negedge fclk)
    if (arst_n) begin
      on_tot += int'(dos_turn_on);
      off_tot += int'(dos_turn_off);
      st_tot += int'(zclk_stall);
      if (dos_turn_on && !zclk_stall) on_wo_st++;
    end
  task automatic run_fetch(input logic [15:0] a, input int n,
                           output int d_on, output int d_off, output int d_st,
                           output logic b_wait);
    int on0, off0, st0;
    on0 = on_tot; off0 = off_tot; st0 = st_tot;
    za = a; m1_n = 0; mreq_n = 0; rfsh_n = 1;
    repeat (n) begin
      @(posedge fclk); #1 zpos = 1;
      @(posedge fclk); #1 zpos = 0;
      @(posedge fclk); #1;
    end
    repeat (8) @(posedge fclk);
    #1 b_wait = busy;
    m1_n = 1; mreq_n = 1;
    @(posedge fclk); #1 zneg = 1;
    @(posedge fclk); #1 zneg = 0;
    repeat (2) @(posedge fclk);
    #1;
    d_on = on_tot - on0; d_off = off_tot - off0; d_st = st_tot - st0;
  endtask
  task automatic check_txn(input string name, input int d_on, input int d_off,
                           input int d_st, input logic bw);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    n_tests++;
    if (d_on !== e.on) begin n_fail++; $display("FAIL %s on_pulses: got %0d want %0d", name, d_on, e.on); end
    n_tests++;
    if (d_off !== e.off) begin n_fail++; $display("FAIL %s off_pulses: got %0d want %0d", name, d_off, e.off); end
    n_tests++;
    if (d_st !== e.st) begin n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", name, d_st, e.st); end
    n_tests++;
    if (bw !== e.bw) begin n_fail++; $display("FAIL %s busy_waitm1: got %b want %b", name, bw, e.bw); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_end: got %b want 0", name, busy); end
  endtask
  task automatic test_reset;
    #1;
    n_tests++;
    if ({dos_turn_on, dos_turn_off, zclk_stall, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000", {dos_turn_on, dos_turn_off, zclk_stall, busy});
    end
    repeat (2) @(posedge fclk);
    #1 arst_n = 1;
    repeat (2) @(posedge fclk);
    #1;
    n_tests++;
    if ({dos_turn_on, dos_turn_off, zclk_stall, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want 0000", {dos_turn_on, dos_turn_off, zclk_stall, busy});
    end
  endtask
  task automatic test_entry;
    int a, b, c; logic bw; int w0;
    dos = 0; pent1m_ROM = 1; win_romnram = 4'b0001; win_dos_7ffd = 4'b0001; pager_off = 0;
    w0 = on_wo_st;
    exp_q.push_back('{1, 0, 4, 1'b1});
    run_fetch(16'h3D2F, 1, a, b, c, bw);
    check_txn("entry", a, b, c, bw);
    n_tests++;
    if (on_wo_st - w0 !== 0) begin n_fail++; $display("FAIL entry_on_with_stall: got %0d misaligned want 0", on_wo_st - w0); end
  endtask
  task automatic test_non_entry;
    int a, b, c; logic bw;
    exp_q.push_back('{0, 0, 0, 1'b0});
    run_fetch(16'h3C00, 1, a, b, c, bw);
    check_txn("non_entry_3C00", a, b, c, bw);
    pent1m_ROM = 0;
    exp_q.push_back('{0, 0, 0, 1'b0});
    run_fetch(16'h3D00, 1, a, b, c, bw);
    check_txn("non_entry_rom128", a, b, c, bw);
    pent1m_ROM = 1;
  endtask
  task automatic test_exit;
    int a, b, c; logic bw;
    dos = 1; win_romnram = 4'b0001;
    exp_q.push_back('{0, EXP_OFF, 0, 1'b0});
    run_fetch(16'h8000, 1, a, b, c, bw);
    check_txn("exit_ram", a, b, c, bw);
    exp_q.push_back('{0, 0, 0, 1'b0});
    run_fetch(16'h3D00, 1, a, b, c, bw);
    check_txn("no_exit_rom", a, b, c, bw);
    dos = 0;
  endtask
  task automatic test_one_shot;
    int a, b, c; logic bw;
    exp_q.push_back('{1, 0, 4, 1'b1});
    run_fetch(16'h3D00, 3, a, b, c, bw);
    check_txn("one_shot", a, b, c, bw);
  endtask
  task automatic test_inhibit;
    int a, b, c; logic bw;
    pager_off = 1;
    exp_q.push_back('{0, 0, 0, 1'b0});
    run_fetch(16'h3D2F, 1, a, b, c, bw);
    check_txn("pager_off", a, b, c, bw);
    pager_off = 0;
  endtask
  task automatic test_reset_mid_stall;
    int a, b, c; logic bw;
    za = 16'h3D10; m1_n = 0; mreq_n = 0; rfsh_n = 1;
    @(posedge fclk); #1 zpos = 1;
    @(posedge fclk); #1 zpos = 0;
    @(posedge fclk); #2;
    n_tests++;
    if (zclk_stall !== 1'b1) begin n_fail++; $display("FAIL stall_2nd_cycle: got %b want 1", zclk_stall); end
    arst_n = 0;
    #1;
    n_tests++;
    if (zclk_stall !== 1'b0) begin n_fail++; $display("FAIL reset_drops_stall: got %b want 0", zclk_stall); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy %b want 0", busy); end
    m1_n = 1; mreq_n = 1;
    @(posedge fclk); #1 arst_n = 1;
    @(posedge fclk); #1;
    exp_q.push_back('{1, 0, 4, 1'b1});
    run_fetch(16'h3DFF, 1, a, b, c, bw);
    check_txn("entry_after_reset", a, b, c, bw);
  endtask
  initial begin
    test_reset;
    test_entry;
    test_non_entry;
    test_exit;
    test_one_shot;
    test_inhibit;
    test_reset_mid_stall;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/atm_dos_ctrl.md
# atm_dos_ctrl

Sequencer for DOS-mode switching in the ATM memory subsystem. It watches Z80 opcode fetches and decides when TR-DOS ROM must be paged in, at 3Dxx in the 48K BASIC ROM, and when it must be paged out, on a fetch from a RAM window. It drives the `dos_turn_on`/`dos_turn_off` strobes consumed by the DOS flag register. It also stalls the Z80 clock long enough for the four window pagers to re-register their page outputs before the fetch completes.

## Interface
Parameters:
- `STALL_CYC`, default 4: fclk cycles `zclk_stall` is held after an entry is detected; legal range 1..7.

Ports:
- `fclk` in 1: system clock.
- `arst_n` in 1: reset, asynchronous, active-low.
- `zpos` in 1: one-fclk strobe at the Z80 clock rising edge.
- `zneg` in 1: one-fclk strobe at the Z80 clock falling edge; used only to sample `m1_n` release.
- `za` in 16: Z80 address bus.
- `m1_n` in 1: Z80 M1, active-low.
- `mreq_n` in 1: Z80 MREQ, active-low.
- `rfsh_n` in 1: Z80 RFSH, active-low.
- `pager_off` in 1: paging disabled (service ROM everywhere); inhibits all switching.
- `dos` in 1: current DOS flag.
- `win_romnram` in 4: per-window ROM(1)/RAM(0), as currently output by the four pagers; bit i is window i (`za[15:14]`=i).
- `win_dos_7ffd` in 4: per-window "DOS enter mode" bit for the currently selected map.
- `pent1m_ROM` in 1: 7FFD bit 4; 1 means the 48K BASIC ROM is selected.
- `dos_turn_on` out 1: one-fclk pulse requesting DOS=1.
- `dos_turn_off` out 1: one-fclk pulse requesting DOS=0.
- `zclk_stall` out 1: hold the Z80 clock.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Fetch strobe `fetch`:
  - Asserted for one fclk when `zpos` is high and `m1_n`=0, `mreq_n`=0, `rfsh_n`=1.
  - Asserted at most once per M1 cycle. Re-armed only after `m1_n`=1 has been sampled on a `zneg` strobe.
- Entry condition, sampled on `fetch`: `!pager_off && !dos && za[15:8]==8'h3D && win_romnram[0] && win_dos_7ffd[0] && pent1m_ROM`.
- Exit condition, sampled on `fetch`: `!pager_off && dos && !win_romnram[za[15:14]]`.
- FSM states:
  - IDLE: on entry condition, go to STALL, pulse `dos_turn_on`, set `cnt`=STALL_CYC-1. On exit condition, pulse `dos_turn_off` without stalling and stay in IDLE.
  - STALL: `zclk_stall`=1. `cnt` decrements each fclk. When `cnt`==0, go to WAITM1.
  - WAITM1: `zclk_stall`=0. Wait for `m1_n`=1 sampled on `zneg`, then go to IDLE. No detection in this state.
- The entry and exit conditions are mutually exclusive because of `dos`; no priority rule is needed.
- `pager_off` rising in STALL does not abort the stall; it only blocks new detections.

## Timing
- Reset values: `dos_turn_on`=0, `dos_turn_off`=0, `zclk_stall`=0, `busy`=0, state IDLE, `cnt`=0, fetch armed.
- Strobe latency: `dos_turn_on` and `dos_turn_off` are registered and appear the fclk after `fetch`.
- Stall timing:
  - `zclk_stall` rises in the same cycle as `dos_turn_on`.
  - It stays high for exactly STALL_CYC fclk cycles.
  - For STALL_CYC=1, the stall lasts one cycle and the FSM then goes directly to WAITM1.
- Reset asserted mid-STALL drops `zclk_stall` immediately (asynchronously).
- A `fetch` arriving while not in IDLE is ignored and does not queue.

## Configuration
- Macro: `ATM_DOS_AUTOEXIT_EN`.
- Defined: exit on a RAM-window fetch behaves as described above.
- Undefined: the exit comparator is not built and `dos_turn_off` is tied to 0. DOS is then left only via external paths (e.g. a port write). Entry behaviour is unchanged.

## Structure
- Shared package `atm_mem_pkg` holds:
  - the FSM state enum `dos_st_t` (IDLE, STALL, WAITM1);
  - the localparam `DOS_ENTRY_PAGE`=8'h3D;
  - the stall counter width `DOS_CNT_W`=3.
- Sub-module `atm_m1_detect` generates the armed one-shot `fetch` strobe from `zpos`, `zneg`, `m1_n`, `mreq_n`, `rfsh_n`. The top level contains the condition logic and the FSM.

## Test plan
- Entry:
  - Stimulus: `dos`=0, `pent1m_ROM`=1, `win_romnram`=4'b0001, `win_dos_7ffd`=4'b0001, M1 fetch at 16'h3D2F.
  - Required: one `dos_turn_on` pulse, then `zclk_stall` high for exactly 4 fclk, then IDLE after `m1_n` goes high.
- Non-entry:
  - Stimulus: same setup, fetch at 16'h3C00; and separately fetch at 16'h3D00 with `pent1m_ROM`=0.
  - Required: no pulses and no stall.
- Exit:
  - Stimulus: `dos`=1, `win_romnram`=4'b0001, fetch at 16'h8000.
  - Required: one `dos_turn_off` pulse and no stall. Without `ATM_DOS_AUTOEXIT_EN`, `dos_turn_off` stays 0.
- One-shot:
  - Stimulus: M1 held low across 3 `zpos` strobes at 16'h3D00.
  - Required: exactly one `dos_turn_on` pulse.
- Inhibit and reset:
  - Stimulus: entry fetch with `pager_off`=1.
  - Required: no action.
  - Stimulus: `arst_n` asserted in the 2nd STALL cycle.
  - Required: `zclk_stall`=0 immediately and FSM in IDLE.
